mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sits directly downstream of the single-cycle MIPS datapath. Consumes its memory address, store data and the controller's read/write strobes.
- Routes each access to synchronous-read data memory or to memory-mapped I/O registers, and returns load data on mem_readdata.
- Loads from data memory take more than one cycle, so the block stalls the datapath by deasserting its enable. Stores and I/O accesses complete with no stall.

Parameters:
- Dbits, 32, data width.
- DMEM_WORDS, 1024, data memory depth in words.
- DMEM_BASE, 32'h1001_0000, data memory base byte address.
- IO_BASE, 32'h1003_0000, I/O register block base byte address.
- RD_LAT, 1, data memory read latency in cycles (legal values 1..7).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  load in the current instruction.
- cpu_wr  in  1  store in the current instruction.
- mem_addr  in  32  byte address from the datapath ALU.
- mem_writedata  in  Dbits  store data.
- mem_readdata  out  Dbits  load data to the datapath.
- enable  out  1  datapath enable; 0 = stall.
- dmem_en  out  1  data memory read strobe.
- dmem_we  out  1  data memory write strobe.
- dmem_addr  out  clog2(DMEM_WORDS)  word index.
- dmem_wdata  out  Dbits  write data.
- dmem_rdata  in  Dbits  read data, valid RD_LAT cycles after dmem_en.
- keyb_char  in  32  keyboard scan value.
- accel_val  in  32  accelerometer value.
- sound_period  out  32  sound generator period register.
- lights  out  16  LED register.

Behaviour:
- Address decode:
  - dmem_hit when (mem_addr - DMEM_BASE) < DMEM_WORDS*4, unsigned.
  - io_hit when mem_addr[31:4] == IO_BASE[31:4].
  - Otherwise unmapped. Address bits [1:0] are ignored.
  - dmem_addr = (mem_addr - DMEM_BASE) >> 2, truncated to the index width.
- I/O offsets:
  - 0x0: keyboard, read-only.
  - 0x4: accelerometer, read-only.
  - 0x8: sound_period, read/write.
  - 0xC: lights, read/write. Writes take bits [15:0]; reads return the value zero-extended.
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - enable = 1.
  - If cpu_rd & dmem_hit & !cpu_wr: assert dmem_en this cycle, drive enable = 0, load cnt = RD_LAT-1, go to WAIT.
  - All other accesses complete in this cycle.
- WAIT:
  - enable = 0.
  - When cnt == 0: capture dmem_rdata into rdata_q and go to DONE. Otherwise decrement cnt.
- DONE:
  - enable = 1; mem_readdata = rdata_q.
  - Next state is IDLE. The datapath advances at the end of DONE, so the load is not reissued.
- Total dmem load time is RD_LAT+2 cycles.
- Stores:
  - dmem_we = cpu_wr & dmem_hit & (state == IDLE); single cycle.
  - I/O register writes are registered on the same edge under the same condition.
  - Writes to read-only offsets and writes to unmapped addresses are ignored.
- Loads outside dmem are combinational with no stall:
  - I/O reads return the selected register or input.
  - Unmapped reads and reserved offsets return 0.
- mem_readdata is 0 whenever neither cpu_rd nor DONE applies.
- If cpu_rd and cpu_wr are asserted together, the write wins: no dmem_en, no stall.
- Reset values:
  - state IDLE, cnt 0, rdata_q 0.
  - sound_period 0, lights 0.
  - enable 1, dmem_en 0, dmem_we 0, mem_readdata 0.
- Reset asserted mid-WAIT: immediately returns to IDLE, discards the pending load, and enable returns to 1 asynchronously.
- dmem_wdata = mem_writedata at all times.
- Back-to-back loads each incur the full stall; there is no forwarding.

Decomposition:
- Package mem_map_pkg holds:
  - default base constants.
  - I/O offset localparams (KEYB_OFS, ACCEL_OFS, SOUND_OFS, LIGHTS_OFS).
  - state enum typedef state_t {IDLE, WAIT, DONE}.
- One sub-module, io_regs, holds the I/O register file and its read mux. The FSM and decode stay in the top.

Test Plan:
- Reset low mid-operation -> enable=1, lights=0, sound_period=0, state IDLE on the next edge with no clock needed.
- RD_LAT=1, store 32'hDEAD_BEEF to 32'h1001_0010, then load from the same address:
  - store: dmem_we=1 for one cycle, dmem_addr=4, enable stays 1.
  - load: enable low for 2 cycles, then mem_readdata=32'hDEAD_BEEF with enable=1.
- RD_LAT=3, same load -> enable low for exactly 4 cycles, then data returned in DONE.
- Store 32'h0001_A5A5 to 32'h1003_000C -> lights=16'hA5A5. A subsequent load from the same address returns 32'h0000_A5A5 with no stall.
- keyb_char=32'h0000_0041, load from 32'h1003_0000 -> mem_readdata=32'h41 in the same cycle. A load from 32'h2000_0000 returns 0 with no stall.
- cpu_rd=cpu_wr=1 at 32'h1001_0000 -> dmem_we=1, dmem_en=0, enable stays 1.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared memory-map constants and FSM state type for the memory access controller.
package mem_map_pkg;

    localparam logic [31:0] DMEM_BASE_DEF = 32'h1001_0000;
    localparam logic [31:0] IO_BASE_DEF   = 32'h1003_0000;

    localparam logic [3:0] KEYB_OFS   = 4'h0;
    localparam logic [3:0] ACCEL_OFS  = 4'h4;
    localparam logic [3:0] SOUND_OFS  = 4'h8;
    localparam logic [3:0] LIGHTS_OFS = 4'hC;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Datapath-side and data-memory-side signals of the memory access controller.
interface mem_access_ctrl_if #(
    parameter int unsigned Dbits = 32,
    parameter int unsigned AW    = 10
);
    logic             cpu_rd;
    logic             cpu_wr;
    logic [31:0]      mem_addr;
    logic [Dbits-1:0] mem_writedata;
    logic [Dbits-1:0] mem_readdata;
    logic             enable;
    logic             dmem_en;
    logic             dmem_we;
    logic [AW-1:0]    dmem_addr;
    logic [Dbits-1:0] dmem_wdata;
    logic [Dbits-1:0] dmem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, mem_addr, mem_writedata, dmem_rdata,
        output mem_readdata, enable, dmem_en, dmem_we, dmem_addr, dmem_wdata
    );

    modport master (
        output cpu_rd, cpu_wr, mem_addr, mem_writedata, dmem_rdata,
        input  mem_readdata, enable, dmem_en, dmem_we, dmem_addr, dmem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl_io_regs.sv
// Memory-mapped I/O register file (sound period, lights) and its read mux.
module io_regs
    import mem_map_pkg::*;
#(
    parameter int unsigned Dbits = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_we,
    input  logic [3:0]       i_ofs,
    input  logic [Dbits-1:0] i_wdata,
    input  logic [31:0]      i_keyb_char,
    input  logic [31:0]      i_accel_val,
    output logic [31:0]      o_sound_period,
    output logic [15:0]      o_lights,
    output logic [Dbits-1:0] o_rdata
);

    logic [3:0]  w_ofs;
    logic [31:0] r_sound_period;
    logic [15:0] r_lights;

    assign w_ofs = {i_ofs[3:2], 2'b00};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sound_period <= '0;
            r_lights       <= '0;
        end else if (i_we) begin
            // read-only offsets fall through and ignore the write
            case (w_ofs)
                SOUND_OFS:  r_sound_period <= 32'(i_wdata);
                LIGHTS_OFS: r_lights       <= i_wdata[15:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        o_rdata = '0;
        case (w_ofs)
            KEYB_OFS:   o_rdata = Dbits'(i_keyb_char);
            ACCEL_OFS:  o_rdata = Dbits'(i_accel_val);
            SOUND_OFS:  o_rdata = Dbits'(r_sound_period);
            LIGHTS_OFS: o_rdata = Dbits'(r_lights);
            default:    o_rdata = '0;
        endcase
    end

    assign o_sound_period = r_sound_period;
    assign o_lights       = r_lights;

endmodule

// File: rtl/mem_access_ctrl.sv
// Routes datapath loads/stores to data memory or I/O registers; stalls the
// datapath while a data-memory load is outstanding.
module mem_access_ctrl
    import mem_map_pkg::*;
#(
    parameter int unsigned Dbits      = 32,
    parameter int unsigned DMEM_WORDS = 1024,
    parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEF,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic              clock,
    input  logic              reset,
    mem_access_ctrl_if.slave  bus,
    input  logic [31:0]       keyb_char,
    input  logic [31:0]       accel_val,
    output logic [31:0]       sound_period,
    output logic [15:0]       lights
);

    localparam int unsigned AW         = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);
    localparam logic [2:0]  CNT_INIT   = 3'(RD_LAT - 1);

    state_t           r_state, w_next;
    logic [2:0]       r_cnt;
    logic [Dbits-1:0] r_rdata_q;

    logic [31:0]      w_ofs;
    logic             w_dmem_hit, w_io_hit, w_idle, w_ld_start, w_st;
    logic [Dbits-1:0] w_io_rdata;

    assign w_ofs      = bus.mem_addr - DMEM_BASE;
    assign w_dmem_hit = (w_ofs < DMEM_BYTES);
    assign w_io_hit   = (bus.mem_addr[31:4] == IO_BASE[31:4]);

    // Gated by reset so strobes and the stall drop the instant reset asserts,
    // even while the datapath still holds its request.
    assign w_idle     = (r_state == IDLE) & reset;
    assign w_ld_start = w_idle & bus.cpu_rd & ~bus.cpu_wr & w_dmem_hit;
    assign w_st       = w_idle & bus.cpu_wr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_ld_start) w_next = WAIT;
            WAIT:    if (r_cnt == 3'd0) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_rdata_q <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_ld_start) r_cnt <= CNT_INIT;
                WAIT: begin
                    if (r_cnt == 3'd0) r_rdata_q <= bus.dmem_rdata;
                    else               r_cnt     <= r_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.enable       = 1'b1;
        bus.dmem_en      = w_ld_start;
        bus.dmem_we      = w_st & w_dmem_hit;
        bus.mem_readdata = '0;
        case (r_state)
            IDLE: begin
                bus.enable = ~w_ld_start;
                if (bus.cpu_rd && w_io_hit) bus.mem_readdata = w_io_rdata;
            end
            WAIT: bus.enable = ~reset;
            DONE: bus.mem_readdata = r_rdata_q;
            default: ;
        endcase
    end

    assign bus.dmem_addr  = w_ofs[AW+1:2];
    assign bus.dmem_wdata = bus.mem_writedata;

    io_regs #(
        .Dbits (Dbits)
    ) u_io_regs (
        .clock          (clock),
        .reset          (reset),
        .i_we           (w_st & w_io_hit),
        .i_ofs          (bus.mem_addr[3:0]),
        .i_wdata        (bus.mem_writedata),
        .i_keyb_char    (keyb_char),
        .i_accel_val    (accel_val),
        .o_sound_period (sound_period),
        .o_lights       (lights),
        .o_rdata        (w_io_rdata)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: two instances (RD_LAT=1 and RD_LAT=3).
module tb_mem_access_ctrl;
    import mem_map_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0, sel = 1'b0;
    logic [31:0] addr = '0, wdata = '0, keyb = '0, accel = '0;
    logic [31:0] sp1, sp3;
    logic [15:0] l1, l3;

    always #5 clock = ~clock;

    mem_access_ctrl_if #(.Dbits(32), .AW(10)) if1 ();
    mem_access_ctrl_if #(.Dbits(32), .AW(10)) if3 ();

    assign if1.cpu_rd        = cpu_rd & ~sel;
    assign if1.cpu_wr        = cpu_wr & ~sel;
    assign if3.cpu_rd        = cpu_rd & sel;
    assign if3.cpu_wr        = cpu_wr & sel;
    assign if1.mem_addr      = addr;
    assign if3.mem_addr      = addr;
    assign if1.mem_writedata = wdata;
    assign if3.mem_writedata = wdata;

    mem_access_ctrl #(.Dbits(32), .DMEM_WORDS(1024), .DMEM_BASE(32'h1001_0000),
                      .IO_BASE(32'h1003_0000), .RD_LAT(1)) u_dut1 (
        .clock(clock), .reset(reset), .bus(if1), .keyb_char(keyb),
        .accel_val(accel), .sound_period(sp1), .lights(l1));

    mem_access_ctrl #(.Dbits(32), .DMEM_WORDS(1024), .DMEM_BASE(32'h1001_0000),
                      .IO_BASE(32'h1003_0000), .RD_LAT(3)) u_dut3 (
        .clock(clock), .reset(reset), .bus(if3), .keyb_char(keyb),
        .accel_val(accel), .sound_period(sp3), .lights(l3));

    // Shared data memory; read data is only valid exactly RD_LAT cycles after dmem_en.
    logic [31:0] mem [0:1023];
    logic [31:0] p1;
    logic [31:0] p3 [0:2];
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else begin
            if (if1.dmem_we) mem[if1.dmem_addr] <= if1.dmem_wdata;
            if (if3.dmem_we) mem[if3.dmem_addr] <= if3.dmem_wdata;
        end
        p1    <= if1.dmem_en ? mem[if1.dmem_addr] : 32'hBAD0_BAD0;
        p3[0] <= if3.dmem_en ? mem[if3.dmem_addr] : 32'hBAD0_BAD0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign if1.dmem_rdata = p1;
    assign if3.dmem_rdata = p3[2];

    logic        w_enable, w_dmem_en, w_dmem_we;
    logic [31:0] w_rdata;
    logic [9:0]  w_daddr;
    assign w_enable  = sel ? if3.enable       : if1.enable;
    assign w_dmem_en = sel ? if3.dmem_en      : if1.dmem_en;
    assign w_dmem_we = sel ? if3.dmem_we      : if1.dmem_we;
    assign w_rdata   = sel ? if3.mem_readdata : if1.mem_readdata;
    assign w_daddr   = sel ? if3.dmem_addr    : if1.dmem_addr;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        we;
        logic        en;
        int unsigned stalls;
        logic [9:0]  daddr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string t, input logic [31:0] rd, input logic we,
                                input logic en, input int unsigned st, input logic [9:0] da);
        exp_t e;
        e.tag = t; e.rdata = rd; e.we = we; e.en = en; e.stalls = st; e.daddr = da;
        return e;
    endfunction

    // Monitor: accumulate stall cycles per access, score on the completing cycle.
    int unsigned m_stalls = 0;
    bit          m_en = 1'b0;
    always @(negedge clock) begin
        if (mon_on && reset && (cpu_rd || cpu_wr)) begin
            m_en = m_en | w_dmem_en;
            if (!w_enable) begin
                m_stalls++;
            end else begin
                if (q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.tag, "_rdata"},  w_rdata,   e.rdata);
                    chk({e.tag, "_we"},     w_dmem_we, e.we);
                    chk({e.tag, "_dmemen"}, m_en,      e.en);
                    chk({e.tag, "_stalls"}, m_stalls,  e.stalls);
                    chk({e.tag, "_daddr"},  w_daddr,   e.daddr);
                end
                m_stalls = 0;
                m_en     = 1'b0;
            end
        end
    end

    task automatic access(input bit s, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input exp_t e);
        bit done = 1'b0;
        q.push_back(e);
        sel = s; cpu_rd = rd; cpu_wr = wr; addr = a; wdata = d;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (w_enable) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk({e.tag, "_timeout"}, 32'd0, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        #1;
    endtask

    initial begin
        #2;
        chk("rst_enable1",   if1.enable,       32'd1);
        chk("rst_enable3",   if3.enable,       32'd1);
        chk("rst_dmem_en",   if1.dmem_en,      32'd0);
        chk("rst_dmem_we",   if1.dmem_we,      32'd0);
        chk("rst_readdata",  if1.mem_readdata, 32'd0);
        chk("rst_lights",    l1,               32'd0);
        chk("rst_sound",     sp1,              32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;

        access(0, 0, 1, 32'h1001_0010, 32'hDEAD_BEEF, mk("st_dmem", 32'h0, 1, 0, 0, 10'd4));
        idle();
        chk("st_we_one_cycle", if1.dmem_we, 32'd0);
        access(0, 1, 0, 32'h1001_0010, 32'h0, mk("ld_lat1", 32'hDEAD_BEEF, 0, 1, 2, 10'd4));
        access(1, 1, 0, 32'h1001_0010, 32'h0, mk("ld_lat3", 32'hDEAD_BEEF, 0, 1, 4, 10'd4));
        idle();

        access(0, 0, 1, 32'h1003_000C, 32'h0001_A5A5, mk("st_lights", 32'h0, 0, 0, 0, 10'd3));
        idle();
        chk("lights_val", l1, 32'h0000_A5A5);
        chk("sound_untouched", sp1, 32'd0);
        access(0, 1, 0, 32'h1003_000C, 32'h0, mk("ld_lights", 32'h0000_A5A5, 0, 0, 0, 10'd3));

        keyb  = 32'h0000_0041;
        accel = 32'hFFFF_FF80;
        access(0, 1, 0, 32'h1003_0000, 32'h0, mk("ld_keyb", 32'h0000_0041, 0, 0, 0, 10'd0));
        access(0, 1, 0, 32'h1003_0005, 32'h0, mk("ld_accel", 32'hFFFF_FF80, 0, 0, 0, 10'd1));
        access(0, 1, 0, 32'h2000_0000, 32'h0, mk("ld_unmapped", 32'h0, 0, 0, 0, 10'd0));
        idle();

        access(0, 0, 1, 32'h1003_0008, 32'h0000_1234, mk("st_sound", 32'h0, 0, 0, 0, 10'd2));
        idle();
        chk("sound_val", sp1, 32'h0000_1234);
        access(0, 0, 1, 32'h1003_0000, 32'hFFFF_FFFF, mk("st_keyb_ro", 32'h0, 0, 0, 0, 10'd0));
        idle();
        chk("ro_keeps_lights", l1, 32'h0000_A5A5);
        chk("ro_keeps_sound",  sp1, 32'h0000_1234);
        access(0, 1, 0, 32'h1003_0008, 32'h0, mk("ld_sound", 32'h0000_1234, 0, 0, 0, 10'd2));

        access(0, 1, 1, 32'h1001_0000, 32'h1234_5678, mk("rdwr", 32'h0, 1, 0, 0, 10'd0));
        access(0, 0, 1, 32'h1001_0FFC, 32'hCAFE_F00D, mk("st_last", 32'h0, 1, 0, 0, 10'd1023));
        access(0, 0, 1, 32'h1001_1000, 32'h1111_1111, mk("st_past_end", 32'h0, 0, 0, 0, 10'd0));
        access(0, 0, 1, 32'h1000_FFFC, 32'h2222_2222, mk("st_below", 32'h0, 0, 0, 0, 10'h3FF));
        idle();
        access(0, 1, 0, 32'h1001_0FFC, 32'h0, mk("b2b_a", 32'hCAFE_F00D, 0, 1, 2, 10'd1023));
        access(0, 1, 0, 32'h1001_0000, 32'h0, mk("b2b_b", 32'h1234_5678, 0, 1, 2, 10'd0));
        idle();
        repeat (2) @(posedge clock);
        #1;

        // Reset in the middle of a pending load, with the request still held.
        mon_on = 1'b0;
        sel = 1'b0; addr = 32'h1001_0000; cpu_rd = 1'b1;
        @(posedge clock); #1;
        chk("wait_stall", if1.enable, 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_enable",  if1.enable,          32'd1);
        chk("midrst_dmem_en", if1.dmem_en,         32'd0);
        chk("midrst_lights",  l1,                  32'd0);
        chk("midrst_sound",   sp1,                 32'd0);
        chk("midrst_state",   32'(u_dut1.r_state), 32'(IDLE));
        cpu_rd = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        chk("queue_drained", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
